btb_setassoc_pipelined: RTL

//  Parametrised set-associative branch target buffer for the fetch front end; successor to the single-cycle BTB.

---
 rtl/btb_pkg.sv | 34 +++
 rtl/btb_victim_sel.sv | 31 +++
 rtl/btb_setassoc_pipelined.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/btb_pkg.sv
// Shared types for the set-associative BTB: entry and update records, FSM states, width helpers.
package btb_pkg;

  localparam int BTB_PC_W = 31;

  typedef struct packed {
    logic                valid;
    logic                used;
    logic                is_jump;
    logic                compr;
    logic [BTB_PC_W-1:0] src;
    logic [BTB_PC_W-1:0] dst;
  } BTBEntry;

  typedef struct packed {
    logic                valid;
    logic                clear;
    logic [BTB_PC_W-1:0] src;
    logic [BTB_PC_W-1:0] dst;
    logic                is_jump;
    logic                compr;
  } BTBUpdate;

  typedef enum logic {ST_CLEAR, ST_IDLE} btb_state_e;

  function automatic int idx_w(input int entries, input int assoc);
    return $clog2(entries / assoc);
  endfunction

  function automatic int way_w(input int assoc);
    return $clog2(assoc);
  endfunction

endpackage

// File: rtl/btb_victim_sel.sv
// Picks the way an update writes: exact match, else lowest invalid, else lowest unused, else round-robin.
module btb_victim_sel
  import btb_pkg::*;
#(
  parameter int ASSOC = 4,
  parameter int WAY_W = way_w(ASSOC)
) (
  input  logic [ASSOC-1:0] valid_i,
  input  logic [ASSOC-1:0] used_i,
  input  logic [ASSOC-1:0] match_i,
  input  logic [WAY_W-1:0] rr_ptr_i,
  output logic [WAY_W-1:0] way_o,
  output logic             is_new_o
);

  // Lowest-priority rule first; each later loop overrides, and descending order makes the lowest way win.
  always_comb begin
    way_o = rr_ptr_i;
    for (int w = ASSOC - 1; w >= 0; w--) begin
      if (!used_i[w]) way_o = WAY_W'(w);
    end
    for (int w = ASSOC - 1; w >= 0; w--) begin
      if (!valid_i[w]) way_o = WAY_W'(w);
    end
    for (int w = ASSOC - 1; w >= 0; w--) begin
      if (match_i[w]) way_o = WAY_W'(w);
    end
    is_new_o = ~|match_i;
  end

endmodule

// File: rtl/btb_setassoc_pipelined.sv
// Set-associative BTB with a registered 1-cycle lookup, in-place update/invalidate,
// NRU replacement with round-robin fallback, and a set-by-set clear sweep after reset.
module btb_setassoc_pipelined
  import btb_pkg::*;
#(
  parameter int NUM_ENTRIES = 64,
  parameter int ASSOC       = 4,
  parameter int PC_W        = BTB_PC_W,
  parameter int OFFS_W      = 2,
  parameter int WAY_W       = way_w(ASSOC)
) (
  input  logic             clk,
  input  logic             rst,
  output logic             OUT_ready,
  input  logic             IN_pcValid,
  input  logic [PC_W-1:0]  IN_pc,
  output logic             OUT_valid,
  output logic             OUT_branchFound,
  output logic [PC_W-1:0]  OUT_branchSrc,
  output logic [PC_W-1:0]  OUT_branchDst,
  output logic             OUT_branchIsJump,
  output logic             OUT_branchCompr,
  output logic             OUT_multipleBranches,
  output logic [WAY_W-1:0] OUT_way,
  input  logic             IN_taken,
  input  logic             IN_updValid,
  input  logic             IN_updClear,
  input  logic [PC_W-1:0]  IN_updSrc,
  input  logic [PC_W-1:0]  IN_updDst,
  input  logic             IN_updIsJump,
  input  logic             IN_updCompr
);

  localparam int NUM_SETS = NUM_ENTRIES / ASSOC;
  localparam int IDX_W    = idx_w(NUM_ENTRIES, ASSOC);
  localparam int TAG_LO   = OFFS_W + IDX_W;

  btb_state_e       state_q;
  logic [IDX_W-1:0] clr_idx_q;
  logic [WAY_W-1:0] rr_q;
  logic             ready_q;
  BTBEntry [ASSOC-1:0] mem_q [NUM_SETS];

  logic             valid_q, found_q, multi_q, is_jump_q, compr_q;
  logic [PC_W-1:0]  src_q, dst_q;
  logic [WAY_W-1:0] way_q;
  logic [IDX_W-1:0] lk_idx_q;

  // ---------------- lookup ----------------
  logic                lk_acc, lk_hit, lk_multi;
  logic [IDX_W-1:0]    lk_idx;
  logic [WAY_W-1:0]    lk_way;
  logic [OFFS_W-1:0]   lk_slot;
  BTBEntry [ASSOC-1:0] lk_row;
  BTBEntry             lk_sel;

  assign lk_acc = IN_pcValid && ready_q;
  assign lk_idx = IN_pc[TAG_LO-1:OFFS_W];
  assign lk_row = mem_q[lk_idx];
  assign lk_sel = lk_row[lk_way];

  always_comb begin
    lk_hit   = 1'b0;
    lk_multi = 1'b0;
    lk_way   = '0;
    lk_slot  = '0;
    for (int w = 0; w < ASSOC; w++) begin
      if (lk_row[w].valid &&
          lk_row[w].src[PC_W-1:OFFS_W] == IN_pc[PC_W-1:OFFS_W] &&
          lk_row[w].src[OFFS_W-1:0] >= IN_pc[OFFS_W-1:0]) begin
        if (lk_hit) lk_multi = 1'b1;
        if (!lk_hit || lk_row[w].src[OFFS_W-1:0] < lk_slot) begin
          lk_way  = WAY_W'(w);
          lk_slot = lk_row[w].src[OFFS_W-1:0];
        end
        lk_hit = 1'b1;
      end
    end
  end

  // ---------------- used-bit feedback (NRU aging) ----------------
  logic                fb_vld;
  logic [ASSOC-1:0]    fb_used;
  BTBEntry [ASSOC-1:0] fb_row;

  assign fb_vld = valid_q && found_q && (IN_taken || is_jump_q);

  always_comb begin
    fb_row  = mem_q[lk_idx_q];
    fb_used = '0;
    for (int w = 0; w < ASSOC; w++) fb_used[w] = fb_row[w].used;
    fb_used[way_q] = 1'b1;
    if (&fb_used) begin
      fb_used        = '0;
      fb_used[way_q] = 1'b1;
    end
    for (int w = 0; w < ASSOC; w++) fb_row[w].used = fb_used[w];
  end

  // ---------------- update ----------------
  BTBUpdate            upd;
  logic                upd_act, upd_new, upd_rr_adv;
  logic [IDX_W-1:0]    upd_idx;
  logic [WAY_W-1:0]    upd_way;
  logic [ASSOC-1:0]    upd_valid, upd_used, upd_match;
  BTBEntry [ASSOC-1:0] upd_old, upd_row;

  assign upd = '{valid: IN_updValid, clear: IN_updClear, src: IN_updSrc,
                 dst: IN_updDst, is_jump: IN_updIsJump, compr: IN_updCompr};
  assign upd_act = upd.valid && ready_q;
  assign upd_idx = upd.src[TAG_LO-1:OFFS_W];
  assign upd_old = mem_q[upd_idx];

  always_comb begin
    for (int w = 0; w < ASSOC; w++) begin
      upd_valid[w] = upd_old[w].valid;
      upd_used[w]  = upd_old[w].used;
      upd_match[w] = upd_old[w].valid && (upd_old[w].src == upd.src);
    end
  end

  btb_victim_sel #(.ASSOC(ASSOC), .WAY_W(WAY_W)) u_victim (
    .valid_i (upd_valid),
    .used_i  (upd_used),
    .match_i (upd_match),
    .rr_ptr_i(rr_q),
    .way_o   (upd_way),
    .is_new_o(upd_new)
  );

  assign upd_rr_adv = upd_act && !upd.clear && upd_new && (&upd_valid) && (&upd_used);

  // Same-set feedback is folded into the update row so both land in one write; the update owns its way.
  always_comb begin
    upd_row = (fb_vld && lk_idx_q == upd_idx) ? fb_row : upd_old;
    if (upd.clear) begin
      if (!upd_new) begin
        upd_row[upd_way].valid = 1'b0;
        upd_row[upd_way].used  = 1'b0;
      end
    end else if (upd_new) begin
      upd_row[upd_way] = '{valid: 1'b1, used: 1'b0, is_jump: upd.is_jump,
                           compr: upd.compr, src: upd.src, dst: upd.dst};
    end else begin
      upd_row[upd_way].dst     = upd.dst;
      upd_row[upd_way].is_jump = upd.is_jump;
      upd_row[upd_way].compr   = upd.compr;
      upd_row[upd_way].used    = upd_old[upd_way].used;
    end
  end

  // ---------------- state ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_CLEAR;
      clr_idx_q <= '0;
      rr_q      <= '0;
      ready_q   <= 1'b0;
      valid_q   <= 1'b0;
      found_q   <= 1'b0;
      multi_q   <= 1'b0;
      way_q     <= '0;
      is_jump_q <= 1'b0;
      compr_q   <= 1'b0;
      src_q     <= '0;
      dst_q     <= '0;
      lk_idx_q  <= '0;
    end else begin
      valid_q <= lk_acc;
      found_q <= lk_acc && lk_hit;
      multi_q <= lk_acc && lk_multi;
      if (lk_acc) begin
        lk_idx_q  <= lk_idx;
        way_q     <= lk_way;
        src_q     <= lk_hit ? lk_sel.src : '0;
        dst_q     <= lk_hit ? lk_sel.dst : '0;
        is_jump_q <= lk_hit && lk_sel.is_jump;
        compr_q   <= lk_hit && lk_sel.compr;
      end
      case (state_q)
        ST_CLEAR: begin
          mem_q[clr_idx_q] <= '0;
          clr_idx_q        <= clr_idx_q + IDX_W'(1);
          if (clr_idx_q == IDX_W'(NUM_SETS - 1)) begin
            state_q <= ST_IDLE;
            ready_q <= 1'b1;
          end
        end
        ST_IDLE: begin
          if (fb_vld) mem_q[lk_idx_q] <= fb_row;
          if (upd_act) mem_q[upd_idx] <= upd_row;
          if (upd_rr_adv) rr_q <= rr_q + WAY_W'(1);
        end
        default: state_q <= ST_CLEAR;
      endcase
    end
  end

  assign OUT_ready            = ready_q;
  assign OUT_valid            = valid_q;
  assign OUT_branchFound      = found_q;
  assign OUT_branchSrc        = src_q;
  assign OUT_branchDst        = dst_q;
  assign OUT_branchIsJump     = is_jump_q;
  assign OUT_branchCompr      = compr_q;
  assign OUT_multipleBranches = multi_q;
  assign OUT_way              = way_q;

endmodule
